// File: rtl/counter_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | counter_pkg : shared encodings for the contador counter and checker   |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
package counter_pkg;

  localparam int COUNTER_WIDTH = 4;

  localparam logic [1:0] MODO_UP3 = 2'b00;
  localparam logic [1:0] MODO_DN1 = 2'b01;
  localparam logic [1:0] MODO_UP1 = 2'b10;
  localparam logic [1:0] MODO_LD  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FILL  = 2'b01,
    CHECK = 2'b10,
    HALT  = 2'b11
  } chk_state_e;

endpackage
`default_nettype wire

// File: rtl/counter_model.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | counter_model : cycle-accurate predictor of contador Q/RCO/LOAD       |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
module counter_model
  import counter_pkg::*;
#(
  parameter int WIDTH = COUNTER_WIDTH
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             enable_i,
  input  logic [1:0]       modo_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] eq_o,
  output logic             erco_o,
  output logic             eload_o
);

  logic [WIDTH-1:0] eq_q, eq_d;
  logic             erco_q, erco_d;
  logic             eload_q, eload_d;
  logic [WIDTH:0]   sum_up3;

  always_comb begin
    sum_up3 = {1'b0, eq_q} + (WIDTH+1)'(3);
    eq_d    = eq_q;
    erco_d  = 1'b0;
    eload_d = 1'b0;
    if (enable_i) begin
      case (modo_i)
        MODO_UP3: begin
          eq_d   = sum_up3[WIDTH-1:0];
          erco_d = sum_up3[WIDTH];
        end
        MODO_DN1: begin
          eq_d   = eq_q - WIDTH'(1);
          erco_d = (eq_q == '0);
        end
        MODO_UP1: begin
          eq_d   = eq_q + WIDTH'(1);
          erco_d = (eq_q == '1);
        end
        MODO_LD: begin
          eq_d    = d_i;
          eload_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      eq_q    <= '0;
      erco_q  <= 1'b0;
      eload_q <= 1'b0;
    end else begin
      eq_q    <= eq_d;
      erco_q  <= erco_d;
      eload_q <= eload_d;
    end
  end

  assign eq_o    = eq_q;
  assign erco_o  = erco_q;
  assign eload_o = eload_q;

endmodule
`default_nettype wire

// File: rtl/counter_checker.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | counter_checker : per-cycle response checker for the contador counter |
// | Optional first-failure capture: COUNTER_CHECKER_FIRST_FAIL_EN         |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
module counter_checker
  import counter_pkg::*;
#(
  parameter int WIDTH        = COUNTER_WIDTH,
  parameter int CMP_DLY      = 0,
  parameter int CNT_W        = 16,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic [1:0]       MODO,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] Q,
  input  logic             RCO,
  input  logic             LOAD,
  output logic             chk_valid,
  output logic             mismatch,
  output logic             fail,
  output logic [CNT_W-1:0] chk_count,
  output logic [CNT_W-1:0] err_count
`ifdef COUNTER_CHECKER_FIRST_FAIL_EN
  ,
  output logic [CNT_W-1:0] ff_cycle,
  output logic [WIDTH+1:0] ff_exp,
  output logic [WIDTH+1:0] ff_act
`endif
);

  logic [WIDTH-1:0] m_eq;
  logic             m_erco;
  logic             m_eload;

  counter_model #(.WIDTH(WIDTH)) u_model (
    .clk      (clk),
    .RESET    (RESET),
    .enable_i (ENABLE),
    .modo_i   (MODO),
    .d_i      (D),
    .eq_o     (m_eq),
    .erco_o   (m_erco),
    .eload_o  (m_eload)
  );

  logic [WIDTH+1:0] exp0;
  logic [WIDTH+1:0] exp_last;
  logic [WIDTH+1:0] act;
  logic             vld0_q;
  logic             vld_last;
  logic             vld_last_nxt;

  assign exp0 = {m_eq, m_erco, m_eload};
  assign act  = {Q, RCO, LOAD};

  // Valid of the model output itself; the delay stages extend this chain.
  always_ff @(posedge clk) begin
    if (RESET) vld0_q <= 1'b0;
    else       vld0_q <= 1'b1;
  end

  generate
    if (CMP_DLY == 0) begin : g_nodly
      assign exp_last     = exp0;
      assign vld_last     = vld0_q;
      assign vld_last_nxt = 1'b1;
    end else begin : g_dly
      logic [WIDTH+1:0] exp_pipe_q [CMP_DLY];
      logic [CMP_DLY-1:0] vld_pipe_q;
      logic [CMP_DLY:0]   vld_chain;

      always_ff @(posedge clk) begin
        exp_pipe_q[0] <= exp0;
        for (int k = 1; k < CMP_DLY; k++) begin
          exp_pipe_q[k] <= exp_pipe_q[k-1];
        end
        if (RESET) begin
          vld_pipe_q <= '0;
        end else begin
          vld_pipe_q[0] <= vld0_q;
          for (int k = 1; k < CMP_DLY; k++) begin
            vld_pipe_q[k] <= vld_pipe_q[k-1];
          end
        end
      end

      assign vld_chain    = {vld_pipe_q, vld0_q};
      assign exp_last     = exp_pipe_q[CMP_DLY-1];
      assign vld_last     = vld_chain[CMP_DLY];
      assign vld_last_nxt = vld_chain[CMP_DLY-1];
    end
  endgenerate

  chk_state_e state_q, state_d;

  always_comb begin
    chk_valid = vld_last && (state_q == CHECK);
    // Case inequality so an unknown on the counter outputs counts as a failure.
    mismatch  = chk_valid && (act !== exp_last);
    state_d   = state_q;
    case (state_q)
      IDLE:    state_d = FILL;
      FILL:    if (vld_last_nxt) state_d = CHECK;
      CHECK:   if ((STOP_ON_FAIL != 0) && mismatch) state_d = HALT;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  logic [CNT_W-1:0] chk_count_q;
  logic [CNT_W-1:0] err_count_q;
  logic             fail_q;

  always_ff @(posedge clk) begin
    if (RESET) begin
      chk_count_q <= '0;
      err_count_q <= '0;
      fail_q      <= 1'b0;
    end else begin
      if (chk_valid && (chk_count_q != '1)) chk_count_q <= chk_count_q + CNT_W'(1);
      if (mismatch) begin
        fail_q <= 1'b1;
        if (err_count_q != '1) err_count_q <= err_count_q + CNT_W'(1);
      end
    end
  end

  assign chk_count = chk_count_q;
  assign err_count = err_count_q;
  assign fail      = fail_q;

`ifdef COUNTER_CHECKER_FIRST_FAIL_EN
  logic [CNT_W-1:0] ff_cycle_q;
  logic [WIDTH+1:0] ff_exp_q;
  logic [WIDTH+1:0] ff_act_q;

  always_ff @(posedge clk) begin
    if (RESET) begin
      ff_cycle_q <= '0;
      ff_exp_q   <= '0;
      ff_act_q   <= '0;
    end else if (mismatch && !fail_q) begin
      ff_cycle_q <= chk_count_q;
      ff_exp_q   <= exp_last;
      ff_act_q   <= act;
    end
  end

  assign ff_cycle = ff_cycle_q;
  assign ff_exp   = ff_exp_q;
  assign ff_act   = ff_act_q;
`endif

endmodule
`default_nettype wire

// File: doc/counter_checker.md
Name: counter_checker

Overview:
- Synthesizable response checker for the 4-bit multi-mode counter (contador); it sits at the output end of the counter interface.
- Snoops the same RESET/ENABLE/MODO/D stimulus the driver applies to the counter and keeps its own cycle-accurate prediction of Q/RCO/LOAD.
- Compares the counter's actual Q/RCO/LOAD against that prediction every cycle and reports mismatch, error and check counts, and a sticky fail flag.
- One instance is attached to the behavioural counter and one to the synthesized counter.

Parameters:
- WIDTH, 4, counter data width (Q, D).
- CMP_DLY, 0, extra cycles the DUT outputs lag the ideal model (0..3); expected values are delayed by this many cycles before compare.
- CNT_W, 16, width of chk_count and err_count.
- STOP_ON_FAIL, 0, 1 = stop checking and counting after the first mismatch.

Ports:
- clk  input  1  rising-edge clock, shared with the counter.
- RESET  input  1  synchronous, active-high reset, shared with the counter.
- ENABLE  input  1  counter enable stimulus.
- MODO  input  2  counter mode stimulus.
- D  input  WIDTH  counter load data stimulus.
- Q  input  WIDTH  counter output under check.
- RCO  input  1  counter ripple-carry output under check.
- LOAD  input  1  counter load-indication output under check.
- chk_valid  output  1  a compare was performed this cycle.
- mismatch  output  1  the compare this cycle failed (combinational from registered expected value vs inputs).
- fail  output  1  sticky: at least one mismatch since reset.
- chk_count  output  CNT_W  number of compares performed, saturating.
- err_count  output  CNT_W  number of mismatches, saturating.

Behaviour:
- Reference model, updated on each clk edge:
  - RESET=1: eQ=0, eRCO=0, eLOAD=0.
  - ENABLE=0: eQ holds; eRCO=0; eLOAD=0.
  - ENABLE=1, MODO=00: eQ=Q+3 mod 2^WIDTH; eRCO=1 iff the true sum exceeds 2^WIDTH-1.
  - ENABLE=1, MODO=01: eQ=Q-1 mod 2^WIDTH; eRCO=1 iff eQ_old=0.
  - ENABLE=1, MODO=10: eQ=Q+1 mod 2^WIDTH; eRCO=1 iff eQ_old=2^WIDTH-1.
  - ENABLE=1, MODO=11: eQ=D; eLOAD=1; eRCO=0.
  - eLOAD=0 in every non-load case.
  - In all cases above, "Q" is the model's own eQ, never the DUT Q.
- Expected values pass through a CMP_DLY-deep shift pipeline, each stage carrying a valid bit.
  - RESET clears all valid bits.
  - Each non-reset edge shifts in valid=1.
  - chk_valid = last stage valid AND state=CHECK.
- State machine (registered):
  - IDLE: entered on RESET. On the first edge with RESET=0 -> FILL.
  - FILL: waits until the last pipeline stage is valid, then -> CHECK. With CMP_DLY=0, FILL lasts one cycle.
  - CHECK: compares. On a mismatch with STOP_ON_FAIL=1 -> HALT; otherwise stays in CHECK.
  - HALT: no compares; chk_valid=0; counters frozen. Exits only via RESET.
- mismatch = chk_valid AND (Q != eQ_d OR RCO != eRCO_d OR LOAD != eLOAD_d).
- On each edge:
  - chk_count increments when chk_valid=1.
  - err_count and fail update when mismatch=1.
  - Both counters saturate at 2^CNT_W-1; fail stays set.
- Reset values: chk_valid=0, mismatch=0, fail=0, chk_count=0, err_count=0, state=IDLE.
- Reset mid-run: everything clears in the same edge; checking restarts through FILL.
- Simultaneous mismatch and saturation: err_count holds at max, fail=1.
- X/Z on Q is treated as a mismatch (case inequality).

Optional Feature:
- Macro: COUNTER_CHECKER_FIRST_FAIL_EN.
- When defined, adds these outputs, captured on the first mismatch only:
  - ff_cycle[CNT_W-1:0]: chk_count value at the first failure.
  - ff_exp[WIDTH+1:0]: {eQ, eRCO, eLOAD} at the first failure.
  - ff_act[WIDTH+1:0]: {Q, RCO, LOAD} at the first failure.
- Captured values are held until RESET and reset to 0.
- When not defined, these ports and registers do not exist and the behaviour is otherwise identical.

Decomposition:
- Shared package counter_pkg:
  - MODO encodings MODO_UP3=2'b00, MODO_DN1=2'b01, MODO_UP1=2'b10, MODO_LD=2'b11.
  - Checker state encodings IDLE/FILL/CHECK/HALT.
  - Default WIDTH.
- One sub-module: counter_model, the pure next-state predictor (eQ/eRCO/eLOAD registers).
- Pipeline, FSM and statistics stay in counter_checker.

Test Plan:
- Reset, then ENABLE=1, MODO=10 for 20 cycles against a correct counter -> Q wraps 15->0 with RCO=1 for one cycle; mismatch never asserts; chk_count=20; err_count=0.
- MODO=00 from Q=12 -> expected Q sequence 15, 2 (RCO=1), 5; a correct DUT gives err_count=0.
- MODO=11 with D=4'hA, then MODO=01 -> Q=A with LOAD=1 for one cycle, then 9, 8; RCO=1 on the 0->F step.
- Inject a fault by forcing Q to 4'h3 for one cycle while expected is 4'h5 -> mismatch=1 that cycle; err_count=1; fail=1 thereafter. With the macro defined, ff_exp Q field=5 and ff_act Q field=3.
- STOP_ON_FAIL=1 with a forced fault -> state HALT; chk_count frozen; RESET pulse returns all outputs to 0.
- CMP_DLY=2 with a DUT delayed two cycles -> FILL lasts 2 cycles; no mismatches; the same DUT checked with CMP_DLY=0 gives err_count>0.
